// File: rtl/tmds_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// tmds_video_timing_ctrl
// Raster timing, control symbols and pixel pull for the three TMDS encoders.
// Revision: 1.0
// ============================================================================
module tmds_video_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 12
) (
    input  logic          pi_clk,
    input  logic          pi_rst,
    input  logic          pi_enable,
    input  logic          pi_clr_err,
    input  logic [23:0]   pi_pix_data,
    input  logic          pi_pix_valid,
    output logic          po_pix_ready,
    output logic          po_display_en,
    output logic [1:0]    po_ctrl_b,
    output logic [1:0]    po_ctrl_g,
    output logic [1:0]    po_ctrl_r,
    output logic [7:0]    po_data_r,
    output logic [7:0]    po_data_g,
    output logic [7:0]    po_data_b,
    output logic [CW-1:0] po_hcount,
    output logic [CW-1:0] po_vcount,
    output logic          po_frame_start,
    output logic          po_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] h, v, h_nxt, v_nxt;
    logic          line_end, frame_end, active, hsync, vsync, running, underrun;

    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);
    assign active    = (h < H_ACT_END) && (v < V_ACT_END);
    assign hsync     = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
    assign vsync     = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
    assign running   = (state != IDLE);

    assign po_pix_ready = running && active;
    // Missing pixel is replaced with black; the raster never stalls.
    assign underrun     = po_pix_ready && !pi_pix_valid;

    assign po_ctrl_g = 2'b00;
    assign po_ctrl_r = 2'b00;

    always_comb begin
        state_nxt = state;
        h_nxt     = h;
        v_nxt     = v;
        case (state)
            IDLE:     if (pi_enable) state_nxt = RUN;
            RUN:      if (!pi_enable) state_nxt = STOPPING;
            STOPPING: begin
                if (pi_enable)      state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
        if (running) begin
            if (line_end) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_nxt = h + 1'b1;
            end
        end else begin
            h_nxt = '0;
            v_nxt = '0;
        end
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state <= IDLE;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_nxt;
            h     <= h_nxt;
            v     <= v_nxt;
        end
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            po_display_en  <= 1'b0;
            po_ctrl_b      <= {~VS_POL, ~HS_POL};
            po_data_r      <= '0;
            po_data_g      <= '0;
            po_data_b      <= '0;
            po_hcount      <= '0;
            po_vcount      <= '0;
            po_frame_start <= 1'b0;
            po_underflow   <= 1'b0;
        end else begin
            if (underrun)        po_underflow <= 1'b1;
            else if (pi_clr_err) po_underflow <= 1'b0;

            if (running) begin
                po_display_en <= active;
                {po_data_r, po_data_g, po_data_b} <= (active && pi_pix_valid) ? pi_pix_data : 24'd0;
                po_ctrl_b      <= {vsync ? VS_POL : ~VS_POL, hsync ? HS_POL : ~HS_POL};
                po_hcount      <= h;
                po_vcount      <= v;
                po_frame_start <= (h == '0) && (v == '0);
            end else begin
                po_display_en  <= 1'b0;
                po_ctrl_b      <= {~VS_POL, ~HS_POL};
                po_data_r      <= '0;
                po_data_g      <= '0;
                po_data_b      <= '0;
                po_hcount      <= '0;
                po_vcount      <= '0;
                po_frame_start <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmds_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tmds_video_timing_ctrl
// Directed bench for the video timing controller on an 8x6 raster.
// Revision: 1.0
// ============================================================================
module tb_tmds_video_timing_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        clr_err;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        display_en;
    logic [1:0]  ctrl_b, ctrl_g, ctrl_r;
    logic [7:0]  data_r, data_g, data_b;
    logic [11:0] hcount, vcount;
    logic        frame_start;
    logic        underflow;

    int vectors     = 0;
    int miscompares = 0;
    int ready_cnt   = 0;
    int seq         = 0;

    tmds_video_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) dut (
        .pi_clk(clk),
        .pi_rst(rst),
        .pi_enable(enable),
        .pi_clr_err(clr_err),
        .pi_pix_data(pix_data),
        .pi_pix_valid(pix_valid),
        .po_pix_ready(pix_ready),
        .po_display_en(display_en),
        .po_ctrl_b(ctrl_b),
        .po_ctrl_g(ctrl_g),
        .po_ctrl_r(ctrl_r),
        .po_data_r(data_r),
        .po_data_g(data_g),
        .po_data_b(data_b),
        .po_hcount(hcount),
        .po_vcount(vcount),
        .po_frame_start(frame_start),
        .po_underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_ready",   32'(pix_ready), 0);
        chk("rst_de",      32'(display_en), 0);
        chk("rst_ctrl_b",  32'(ctrl_b), 32'h3);
        chk("rst_ctrl_g",  32'(ctrl_g), 0);
        chk("rst_ctrl_r",  32'(ctrl_r), 0);
        chk("rst_data",    32'({data_r, data_g, data_b}), 0);
        chk("rst_hcount",  32'(hcount), 0);
        chk("rst_vcount",  32'(vcount), 0);
        chk("rst_fs",      32'(frame_start), 0);
        chk("rst_uflow",   32'(underflow), 0);
    endtask

    // One pixel clock: (ph,pv) is the internal position during this cycle,
    // the outputs are checked for it one edge later.
    task automatic cyc(input int ph, input int pv, input bit running);
        bit          act;
        logic [23:0] sent;
        act      = running && (ph < 4) && (pv < 3);
        pix_data = 24'(32'h00A510 + seq * 32'h010203);
        sent     = pix_data;
        seq++;
        chk("pix_ready", 32'(pix_ready), 32'(act));
        if (pix_ready) ready_cnt++;
        tick();
        chk("display_en", 32'(display_en), 32'(act));
        chk("data", 32'({data_r, data_g, data_b}), (act && pix_valid) ? 32'(sent) : 32'd0);
        chk("ctrl_b", 32'(ctrl_b),
            running ? 32'({(pv != 4), !(ph == 5 || ph == 6)}) : 32'h3);
        chk("ctrl_gr", 32'({ctrl_g, ctrl_r}), 0);
        chk("hcount", 32'(hcount), running ? 32'(ph) : 32'd0);
        chk("vcount", 32'(vcount), running ? 32'(pv) : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(running && ph == 0 && pv == 0));
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        clr_err   = 1'b0;
        pix_data  = '0;
        pix_valid = 1'b0;
        tick();
        reset_checks();

        // Release and run a clean frame with continuous valid
        rst       = 1'b0;
        enable    = 1'b1;
        pix_valid = 1'b1;
        tick();
        ready_cnt = 0;
        for (int k = 0; k < 48; k++) cyc(k % 8, k / 8, 1'b1);
        chk("ready_per_frame", 32'(ready_cnt), 12);

        // Valid dropped at h=2,v=1
        for (int k = 0; k < 48; k++) begin
            pix_valid = (k != 10);
            cyc(k % 8, k / 8, 1'b1);
            chk("underflow_drop", 32'(underflow), 32'(k >= 10));
        end
        pix_valid = 1'b1;

        // Clear, then clear coincident with a new underflow at h=1,v=2
        for (int k = 0; k < 48; k++) begin
            clr_err   = (k == 0 || k == 17);
            pix_valid = (k != 17);
            cyc(k % 8, k / 8, 1'b1);
            chk("underflow_clr", 32'(underflow), 32'(k >= 17));
        end
        clr_err   = 1'b0;
        pix_valid = 1'b1;

        // Stop requested at h=3,v=1, withdrawn at h=7,v=3
        for (int k = 0; k < 48; k++) begin
            if (k == 11) enable = 1'b0;
            if (k == 31) enable = 1'b1;
            cyc(k % 8, k / 8, 1'b1);
        end

        // Stop requested at h=3,v=1 and held: frame completes then idles
        for (int k = 0; k < 48; k++) begin
            if (k == 11) enable = 1'b0;
            cyc(k % 8, k / 8, 1'b1);
        end
        for (int k = 0; k < 3; k++) cyc(0, 0, 1'b0);
        chk("underflow_idle_kept", 32'(underflow), 1);

        // Restart, then reset mid-frame at h=5,v=2
        enable = 1'b1;
        tick();
        for (int k = 0; k < 21; k++) cyc(k % 8, k / 8, 1'b1);
        rst = 1'b1;
        #1;
        reset_checks();
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) cyc(k % 8, k / 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
